// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus of dmem_arbiter.
// The slave modport is the arbiter's view. The master modport is the view
// of everything around it: the requesters and the memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req_i;
  logic              p0_we_i;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_wdata_i;
  logic              p0_gnt_o;
  logic              p0_done_o;
  logic [DATA_W-1:0] p0_rdata_o;

  logic              p1_req_i;
  logic              p1_we_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_wdata_i;
  logic              p1_gnt_o;
  logic              p1_done_o;
  logic [DATA_W-1:0] p1_rdata_o;

  logic              mem_read_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              busy_o;

  modport slave (
    input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    input  mem_rdata_i,
    output p0_gnt_o, p0_done_o, p0_rdata_o,
    output p1_gnt_o, p1_done_o, p1_rdata_o,
    output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, busy_o
  );

  modport master (
    output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    output mem_rdata_i,
    input  p0_gnt_o, p0_done_o, p0_rdata_o,
    input  p1_gnt_o, p1_done_o, p1_rdata_o,
    input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port data
// memory. Port 0 is the MEM stage and port 1 is the loader/debug master.
// Each access holds the memory strobe for LAT cycles. It is followed by one
// DONE cycle, in which the other port may be granted straight away.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  state_t            state;
  logic [1:0]        cnt;
  logic              last;
  logic              win;

  logic              req0;
  logic              req1;
  logic              start;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Round-robin choice: a lone requester wins; on a tie, the port that was
  // not served last wins.
  function automatic logic arb_pick(input logic r0, input logic r1, input logic lst);
    logic w;
    if (r0 && r1) w = ~lst;
    else          w = r1;
    return w;
  endfunction

  // Request masking, winner selection and the winner's fields.
  // In DONE, the port that was just served still holds req while it samples
  // done, so its request is ignored for that one cycle.
  always_comb begin
    req0 = bus.p0_req_i;
    req1 = bus.p1_req_i;
    if (state == DONE) begin
      if (win) req1 = 1'b0;
      else     req0 = 1'b0;
    end
    start     = (state != ACCESS) && (req0 || req1);
    pick      = arb_pick(req0, req1, last);
    sel_we    = pick ? bus.p1_we_i    : bus.p0_we_i;
    sel_addr  = pick ? bus.p1_addr_i  : bus.p0_addr_i;
    sel_wdata = pick ? bus.p1_wdata_i : bus.p0_wdata_i;
  end

  // Access sequencer FSM. All outputs are registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      cnt             <= 2'd0;
      last            <= 1'b1;
      win             <= 1'b0;
      bus.p0_gnt_o    <= 1'b0;
      bus.p1_gnt_o    <= 1'b0;
      bus.p0_done_o   <= 1'b0;
      bus.p1_done_o   <= 1'b0;
      bus.p0_rdata_o  <= '0;
      bus.p1_rdata_o  <= '0;
      bus.mem_read_o  <= 1'b0;
      bus.mem_write_o <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
    end else begin
      bus.p0_done_o <= 1'b0;
      bus.p1_done_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            win             <= pick;
            last            <= pick;
            bus.p0_gnt_o    <= ~pick;
            bus.p1_gnt_o    <= pick;
            bus.mem_read_o  <= ~sel_we;
            bus.mem_write_o <= sel_we;
            bus.mem_addr_o  <= sel_addr;
            bus.mem_wdata_o <= sel_wdata;
            cnt             <= CNT_INIT;
            state           <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt == 2'd0) begin
            if (bus.mem_read_o) begin
              if (win) bus.p1_rdata_o <= bus.mem_rdata_i;
              else     bus.p0_rdata_o <= bus.mem_rdata_i;
            end
            if (win) bus.p1_done_o <= 1'b1;
            else     bus.p0_done_o <= 1'b1;
            bus.mem_read_o  <= 1'b0;
            bus.mem_write_o <= 1'b0;
            bus.p0_gnt_o    <= 1'b0;
            bus.p1_gnt_o    <= 1'b0;
            state           <= DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Two instances (LAT=1 and LAT=3) receive the same
// kind of traffic. Each instance is compared every cycle against a
// timeline model: an access granted at edge G strobes during G..G+LAT-1,
// pulses done at G+LAT, and lets the next grant happen from edge G+LAT+1.
module tb_dmem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT_A)) u_dut_a (.clk_i(clk), .rst_i(rst_n), .bus(bus_a));
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT_B)) u_dut_b (.clk_i(clk), .rst_i(rst_n), .bus(bus_b));

  // driven inputs [instance][port]
  logic        d_req[2][2];
  logic        d_we[2][2];
  logic [31:0] d_addr[2][2];
  logic [31:0] d_wdata[2][2];
  logic [31:0] d_mrd[2];

  assign bus_a.p0_req_i = d_req[0][0];  assign bus_a.p1_req_i = d_req[0][1];
  assign bus_a.p0_we_i = d_we[0][0];    assign bus_a.p1_we_i = d_we[0][1];
  assign bus_a.p0_addr_i = d_addr[0][0]; assign bus_a.p1_addr_i = d_addr[0][1];
  assign bus_a.p0_wdata_i = d_wdata[0][0]; assign bus_a.p1_wdata_i = d_wdata[0][1];
  assign bus_a.mem_rdata_i = d_mrd[0];
  assign bus_b.p0_req_i = d_req[1][0];  assign bus_b.p1_req_i = d_req[1][1];
  assign bus_b.p0_we_i = d_we[1][0];    assign bus_b.p1_we_i = d_we[1][1];
  assign bus_b.p0_addr_i = d_addr[1][0]; assign bus_b.p1_addr_i = d_addr[1][1];
  assign bus_b.p0_wdata_i = d_wdata[1][0]; assign bus_b.p1_wdata_i = d_wdata[1][1];
  assign bus_b.mem_rdata_i = d_mrd[1];

  // observed outputs
  logic        o_gnt[2][2];
  logic        o_done[2][2];
  logic [31:0] o_rdata[2][2];
  logic        o_rd[2], o_wr[2], o_busy[2];
  logic [31:0] o_addr[2], o_wdata[2];

  assign o_gnt[0][0] = bus_a.p0_gnt_o;   assign o_gnt[0][1] = bus_a.p1_gnt_o;
  assign o_done[0][0] = bus_a.p0_done_o; assign o_done[0][1] = bus_a.p1_done_o;
  assign o_rdata[0][0] = bus_a.p0_rdata_o; assign o_rdata[0][1] = bus_a.p1_rdata_o;
  assign o_rd[0] = bus_a.mem_read_o;  assign o_wr[0] = bus_a.mem_write_o;  assign o_busy[0] = bus_a.busy_o;
  assign o_addr[0] = bus_a.mem_addr_o; assign o_wdata[0] = bus_a.mem_wdata_o;
  assign o_gnt[1][0] = bus_b.p0_gnt_o;   assign o_gnt[1][1] = bus_b.p1_gnt_o;
  assign o_done[1][0] = bus_b.p0_done_o; assign o_done[1][1] = bus_b.p1_done_o;
  assign o_rdata[1][0] = bus_b.p0_rdata_o; assign o_rdata[1][1] = bus_b.p1_rdata_o;
  assign o_rd[1] = bus_b.mem_read_o;  assign o_wr[1] = bus_b.mem_write_o;  assign o_busy[1] = bus_b.busy_o;
  assign o_addr[1] = bus_b.mem_addr_o; assign o_wdata[1] = bus_b.mem_wdata_o;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic string tg(input string s, input int k, input int p);
    return $sformatf("%s_%s_p%0d", s, (k == 0) ? "lat1" : "lat3", p);
  endfunction

  // ---------------- reference model ----------------
  int          lat[2] = '{LAT_A, LAT_B};
  bit          m_has[2];
  int          m_g[2];
  int          m_port[2];
  logic        m_we[2];
  logic [31:0] m_addr[2], m_wdata[2];
  logic [31:0] m_rdata[2][2];
  int          m_last[2];
  int          cyc = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_has[k] = 1'b0; m_g[k] = 0; m_port[k] = 0; m_last[k] = 1;
      m_we[k] = 1'b0; m_addr[k] = '0; m_wdata[k] = '0;
      m_rdata[k][0] = '0; m_rdata[k][1] = '0;
    end
  endtask

  function automatic bit m_act(input int k, input int c);
    return m_has[k] && (c >= m_g[k]) && (c <= m_g[k] + lat[k] - 1);
  endfunction

  function automatic bit m_done(input int k, input int c);
    return m_has[k] && (c == m_g[k] + lat[k]);
  endfunction

  // Apply the edge e = cyc+1 using the inputs that are driven now.
  task automatic model_edge();
    int  e;
    bit  r0, r1;
    int  w;
    e = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_has[k] = 1'b0; m_last[k] = 1; m_addr[k] = '0; m_wdata[k] = '0;
        m_rdata[k][0] = '0; m_rdata[k][1] = '0;
      end else begin
        if (m_has[k] && e == m_g[k] + lat[k] && !m_we[k])
          m_rdata[k][m_port[k]] = d_mrd[k];
        if (!m_has[k] || e >= m_g[k] + lat[k] + 1) begin
          r0 = d_req[k][0];
          r1 = d_req[k][1];
          if (m_has[k] && e == m_g[k] + lat[k] + 1) begin
            if (m_port[k] == 0) r0 = 1'b0;
            else                r1 = 1'b0;
          end
          if (r0 || r1) begin
            if (r0 && r1) w = 1 - m_last[k];
            else          w = r1 ? 1 : 0;
            m_has[k] = 1'b1; m_g[k] = e; m_port[k] = w; m_last[k] = w;
            m_we[k] = d_we[k][w]; m_addr[k] = d_addr[k][w]; m_wdata[k] = d_wdata[k][w];
          end
        end
      end
    end
  endtask

  // ---------------- requesters ----------------
  bit          rq_out[2][2];
  int          rate = 0;
  int          drop_pct = 0;
  bit          cont = 1'b0;
  bit          scramble = 1'b0;
  bit          rd_fixed = 1'b0;
  bit          pend_v[2];
  logic        pend_we[2];
  logic [31:0] pend_addr[2], pend_wdata[2];
  logic        prev_gnt[2][2];
  int          gq_a[$], gq_b[$];

  task automatic rand_fields(input int k, input int p);
    d_we[k][p]    = 1'($urandom_range(0, 1));
    d_addr[k][p]  = $urandom;
    d_wdata[k][p] = $urandom;
  endtask

  task automatic check_cycle();
    bit act, dn;
    for (int k = 0; k < 2; k++) begin
      act = m_act(k, cyc);
      dn  = m_done(k, cyc);
      for (int p = 0; p < 2; p++) begin
        check(tg("gnt", k, p), 32'(o_gnt[k][p]), 32'(act && m_port[k] == p));
        check(tg("done", k, p), 32'(o_done[k][p]), 32'(dn && m_port[k] == p));
        check(tg("rdata", k, p), o_rdata[k][p], m_rdata[k][p]);
      end
      check(tg("mem_read", k, 0), 32'(o_rd[k]), 32'(act && !m_we[k]));
      check(tg("mem_write", k, 0), 32'(o_wr[k]), 32'(act && m_we[k]));
      check(tg("busy", k, 0), 32'(o_busy[k]), 32'(act || dn));
      if (act) begin
        check(tg("mem_addr", k, 0), o_addr[k], m_addr[k]);
        check(tg("mem_wdata", k, 0), o_wdata[k], m_wdata[k]);
      end
      check(tg("gnt_excl", k, 0), 32'(o_gnt[k][0] & o_gnt[k][1]), 32'd0);
      check(tg("done_excl", k, 0), 32'(o_done[k][0] & o_done[k][1]), 32'd0);
      check(tg("strobe_excl", k, 0), 32'(o_rd[k] & o_wr[k]), 32'd0);
    end
  endtask

  task automatic check_reset_zero(input string s);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        check(tg({s, "_gnt"}, k, p), 32'(o_gnt[k][p]), 32'd0);
        check(tg({s, "_done"}, k, p), 32'(o_done[k][p]), 32'd0);
        check(tg({s, "_rdata"}, k, p), o_rdata[k][p], 32'd0);
      end
      check(tg({s, "_rd"}, k, 0), 32'(o_rd[k]), 32'd0);
      check(tg({s, "_wr"}, k, 0), 32'(o_wr[k]), 32'd0);
      check(tg({s, "_busy"}, k, 0), 32'(o_busy[k]), 32'd0);
      check(tg({s, "_addr"}, k, 0), o_addr[k], 32'd0);
      check(tg({s, "_wdata"}, k, 0), o_wdata[k], 32'd0);
    end
  endtask

  // One clock: check the current cycle, choose the next inputs, advance the model.
  task automatic step(input logic rst_val);
    bit g, dn;
    @(negedge clk);
    cyc++;
    check_cycle();
    for (int p = 0; p < 2; p++) begin
      if (o_gnt[0][p] && !prev_gnt[0][p]) gq_a.push_back(p);
      if (o_gnt[1][p] && !prev_gnt[1][p]) gq_b.push_back(p);
    end
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        g  = m_act(k, cyc) && m_port[k] == p;
        dn = m_done(k, cyc) && m_port[k] == p;
        if (dn) begin
          rq_out[k][p] = 1'b0;
          d_req[k][p]  = 1'b0;
        end
        if (rq_out[k][p]) begin
          if (g && scramble) rand_fields(k, p);
          if (g && d_req[k][p] && $urandom_range(0, 99) < drop_pct) d_req[k][p] = 1'b0;
        end else if (pend_v[p]) begin
          d_req[k][p] = 1'b1; d_we[k][p] = pend_we[p];
          d_addr[k][p] = pend_addr[p]; d_wdata[k][p] = pend_wdata[p];
          rq_out[k][p] = 1'b1;
        end else if (cont || $urandom_range(0, 99) < rate) begin
          d_req[k][p] = 1'b1;
          rand_fields(k, p);
          rq_out[k][p] = 1'b1;
        end
      end
      d_mrd[k] = rd_fixed ? 32'hDEADBEEF : $urandom;
    end
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    rst_n = rst_val;
    model_edge();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) prev_gnt[k][p] = o_gnt[k][p];
  endtask

  task automatic post(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    pend_v[p] = 1'b1; pend_we[p] = we; pend_addr[p] = addr; pend_wdata[p] = wdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int n_rd[2], n_wr[2], n_dn[2];
    bit seen[2];
    // async reset at time 0, before any clock edge
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_mrd[k] = '0;
      for (int p = 0; p < 2; p++) begin
        d_req[k][p] = 1'b0; d_we[k][p] = 1'b0; d_addr[k][p] = '0; d_wdata[k][p] = '0;
        rq_out[k][p] = 1'b0; prev_gnt[k][p] = 1'b0;
      end
    end
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    model_reset();
    #1;
    check_reset_zero("rst0");
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1);

    // single read of 0x10 returning DEADBEEF
    rd_fixed = 1'b1;
    post(0, 1'b0, 32'h10, 32'h0);
    n_rd = '{0, 0}; seen = '{0, 0};
    for (int i = 0; i < 20 && !(seen[0] && seen[1]); i++) begin
      step(1'b1);
      for (int k = 0; k < 2; k++) begin
        if (o_rd[k]) n_rd[k]++;
        if (o_done[k][0] && !seen[k]) begin
          seen[k] = 1'b1;
          check(tg("rd_deadbeef", k, 0), o_rdata[k][0], 32'hDEADBEEF);
        end
      end
    end
    rd_fixed = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check(tg("rd_done_seen", k, 0), 32'(seen[k]), 32'd1);
      check(tg("rd_strobe_len", k, 0), n_rd[k], lat[k]);
    end
    step(1'b1);

    // single write of 0x12345678 to 0x04 from port 1
    post(1, 1'b1, 32'h04, 32'h12345678);
    n_wr = '{0, 0}; seen = '{0, 0};
    for (int i = 0; i < 20 && !(seen[0] && seen[1]); i++) begin
      step(1'b1);
      for (int k = 0; k < 2; k++) begin
        if (o_wr[k]) begin
          n_wr[k]++;
          check(tg("wr_addr", k, 1), o_addr[k], 32'h04);
          check(tg("wr_data", k, 1), o_wdata[k], 32'h12345678);
        end
        if (o_done[k][1] && !seen[k]) begin
          seen[k] = 1'b1;
          check(tg("wr_rdata_kept", k, 1), o_rdata[k][1], 32'd0);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      check(tg("wr_done_seen", k, 1), 32'(seen[k]), 32'd1);
      check(tg("wr_strobe_len", k, 1), n_wr[k], lat[k]);
    end
    step(1'b1);

    // both ports request continuously: grants alternate starting with port 0
    gq_a.delete(); gq_b.delete();
    cont = 1'b1;
    for (int i = 0; i < 60 && !(gq_a.size() >= 4 && gq_b.size() >= 4); i++) step(1'b1);
    cont = 1'b0;
    check("order_len_lat1", 32'(gq_a.size() >= 4), 32'd1);
    check("order_len_lat3", 32'(gq_b.size() >= 4), 32'd1);
    if (gq_a.size() >= 4 && gq_b.size() >= 4) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("order_lat1_%0d", j), gq_a[j], j % 2);
        check($sformatf("order_lat3_%0d", j), gq_b[j], j % 2);
      end
    end
    for (int i = 0; i < 15; i++) step(1'b1);

    // reset in the second access cycle of the LAT=3 instance
    post(0, 1'b0, 32'h20, 32'h0);
    seen = '{0, 0};
    for (int i = 0; i < 20 && !seen[0]; i++) begin
      step(1'b1);
      if (m_act(1, cyc) && cyc == m_g[1] + 1) seen[0] = 1'b1;
    end
    check("rst_mid_reached", 32'(seen[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_zero("rst_mid");
    model_reset();
    step(1'b0);
    n_rd = '{0, 0}; n_dn = '{0, 0}; seen = '{0, 0};
    step(1'b1);
    for (int i = 0; i < 20 && !seen[1]; i++) begin
      step(1'b1);
      if (o_rd[1]) n_rd[1]++;
      if (o_done[1][0]) begin
        seen[1] = 1'b1;
        n_dn[1]++;
      end
    end
    check("rst_mid_reissue_done", 32'(seen[1]), 32'd1);
    check("rst_mid_reissue_len", n_rd[1], LAT_B);
    for (int i = 0; i < 5; i++) step(1'b1);

    // port 0 drops its request right after being granted
    drop_pct = 100;
    post(0, 1'b0, 32'h30, 32'h0);
    n_dn = '{0, 0}; n_rd = '{0, 0};
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      for (int k = 0; k < 2; k++) begin
        if (o_done[k][0]) n_dn[k]++;
        if (o_rd[k]) n_rd[k]++;
      end
    end
    drop_pct = 0;
    for (int k = 0; k < 2; k++) begin
      check(tg("drop_done_once", k, 0), n_dn[k], 1);
      check(tg("drop_strobe_len", k, 0), n_rd[k], lat[k]);
    end

    // random traffic: field changes while granted and occasional early drops
    rate = 30; scramble = 1'b1; drop_pct = 10;
    for (int i = 0; i < 1500; i++) step(1'b1);
    rate = 0; scramble = 1'b0; drop_pct = 0;
    for (int i = 0; i < 15; i++) step(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the single-port data memory.
- Port 0 is the pipeline MEM stage; port 1 is the secondary master (loader/debug).
- Grants one requester at a time using round-robin and drives the memory read/write strobes for a fixed LAT cycles.
- Returns read data and a one-cycle done pulse to the granted port; exposes busy_o so the hazard unit can stall.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LAT, 1, cycles the memory strobe is held per access (legal 1..4).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous active-low reset.
- p0_req_i  in  1  port 0 request; held with fields stable until p0_done_o.
- p0_we_i  in  1  port 0 operation: 1 = write, 0 = read.
- p0_addr_i  in  ADDR_W  port 0 address.
- p0_wdata_i  in  DATA_W  port 0 write data.
- p0_gnt_o  out  1  port 0 owns the memory.
- p0_done_o  out  1  one-cycle completion pulse for port 0.
- p0_rdata_o  out  DATA_W  port 0 read data, registered.
- p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_gnt_o, p1_done_o, p1_rdata_o: same as port 0, for port 1.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data; valid during the last strobe cycle.
- busy_o  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (asynchronous, rst_i=0):
  - state=IDLE, cnt=0, all gnt/done/strobes=0.
  - mem_addr_o, mem_wdata_o, p0_rdata_o, p1_rdata_o = 0.
  - last=1, so port 0 wins the first tie.
  - Reset asserted mid-access aborts it: no done pulse, and any write in progress is unspecified in memory.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select a winner, register the winner's we/addr/wdata into the mem_* outputs, set gnt, set cnt=LAT-1, go to ACCESS.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the port not equal to last wins.
  - last updates to the winner on entry to ACCESS.
- ACCESS:
  - gnt of the winner = 1.
  - mem_read_o = ~we, mem_write_o = we; both held constant for exactly LAT cycles.
  - Address and data outputs are stable for the whole access.
  - cnt decrements each cycle. On the cycle with cnt==0:
    - for a read, capture mem_rdata_i into the winner's rdata register;
    - go to DONE.
- DONE:
  - Strobes=0, gnt=0, winner's done_o=1 for exactly this cycle.
  - rdata_o is valid in this cycle and holds until that port's next read completes.
  - Writes leave rdata_o unchanged.
- DONE re-arbitration:
  - Arbitrate as in IDLE, but ignore the just-served port's request this cycle (it is still high while it samples done).
  - A pending request from the other port goes straight to ACCESS (no bubble); otherwise go to IDLE.
- Latency:
  - Request sampled at edge N → gnt and strobes from N+1 through N+LAT.
  - done_o at cycle N+LAT+1.
  - Back-to-back accesses to alternating ports: one DONE cycle between strobe bursts.
- Request protocol:
  - Deasserting req before done does not abort; the access completes and done still pulses.
  - Field changes while granted are ignored, since the fields were latched at grant.
- Both done outputs never high together; both gnt outputs never high together; mem_read_o and mem_write_o never high together.
- Address and data pass through unmodified; alignment is the memory's concern.

Test Plan:
- Reset then idle: rst_i low asynchronously mid-cycle → all outputs 0 immediately; after release with no req, strobes stay 0 for 10 cycles.
- Single read, LAT=1: p0 read addr 0x10, mem_rdata_i=0xDEADBEEF → mem_read_o high for 1 cycle at N+1; p0_done_o=1 and p0_rdata_o=0xDEADBEEF at N+2.
- Single write, LAT=3: p1 write addr 0x04, data 0x12345678 → mem_write_o high for exactly 3 cycles with stable addr/data; p1_done_o at N+4; p1_rdata_o unchanged.
- Simultaneous requests held continuously for 4 grants, LAT=1 → grant order p0, p1, p0, p1; DONE goes directly to ACCESS each time; never two gnt high.
- Reset mid-access: assert rst_i in the second ACCESS cycle with LAT=3 → no done pulse; after release with p0 still requesting, a fresh full 3-cycle access is issued.
- Early req drop: p0 read, drop p0_req_i one cycle after grant → access still runs LAT cycles and p0_done_o still pulses once.
